// File: rtl/sarray_storec_drain.sv
// Drains C-tile rows from the systolic array bottom edge into a credit-managed FIFO and writes them out.
// Optional build macro: SARRAY_DRAIN_CNT_CHECK_EN enables bot_cnt_i row-tag checking.
module sarray_storec_drain #(
    parameter int DATA_W     = 512,
    parameter int CNT_W      = 8,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int ROW_STRIDE = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  rows_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              post_storec_valid_o,
    input  logic              bot_valid_i,
    input  logic [CNT_W-1:0]  bot_cnt_i,
    input  logic [DATA_W-1:0] bot_data_i,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              err_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  rows_q, req_cnt, rx_cnt, wr_cnt;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic              err_q;

    logic [CNT_W-1:0]  inflight;
    logic [CNT_W:0]    committed;
    logic              fifo_full, fifo_empty;
    logic              push, pop, issue, accept_start, rx_live, drop, tag_bad;

    assign accept_start = (state == IDLE) && start_i;
    assign fifo_full    = (occ == OCC_W'(FIFO_DEPTH));
    assign fifo_empty   = (occ == '0);
    assign pop          = !fifo_empty && wr_ready_i;
    assign rx_live      = bot_valid_i && (state != IDLE);
    assign push         = rx_live && (!fifo_full || pop);
    assign drop         = bot_valid_i && !push;

    // Slots already spoken for: buffered rows plus rows requested but not yet returned.
    // The array cannot stall, so a request only goes out when a slot is guaranteed.
    assign inflight  = req_cnt - rx_cnt;
    assign committed = {1'b0, inflight} + (CNT_W+1)'(occ);
    assign issue     = (state == ISSUE) && (req_cnt < rows_q) &&
                       (committed < (CNT_W+1)'(FIFO_DEPTH));

`ifdef SARRAY_DRAIN_CNT_CHECK_EN
    assign tag_bad = rx_live && (bot_cnt_i != rx_cnt);
`else
    logic unused_cnt;
    assign unused_cnt = ^bot_cnt_i;
    assign tag_bad    = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = (rows_i == '0) ? FIN : ISSUE;
            ISSUE:   if (req_cnt == rows_q) state_next = WAIT;
            WAIT:    if (wr_cnt == rows_q) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rows_q  <= '0;
            base_q  <= '0;
            req_cnt <= '0;
            rx_cnt  <= '0;
            wr_cnt  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept_start) begin
                rows_q  <= rows_i;
                base_q  <= base_addr_i;
                req_cnt <= '0;
                rx_cnt  <= '0;
                wr_cnt  <= '0;
                err_q   <= 1'b0;
            end else begin
                if (issue)          req_cnt <= req_cnt + 1'b1;
                if (rx_live)        rx_cnt  <= rx_cnt + 1'b1;
                if (pop)            wr_cnt  <= wr_cnt + 1'b1;
                if (drop || tag_bad) err_q  <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      occ <= occ + 1'b1;
            else if (pop && !push) occ <= occ - 1'b1;
        end
    end

    // Row storage carries no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bot_data_i;
    end

    assign busy_o              = (state != IDLE);
    assign done_o              = (state == FIN);
    assign post_storec_valid_o = issue;
    assign wr_valid_o          = !fifo_empty;
    assign wr_data_o           = fifo_empty ? '0 : mem[rd_ptr];
    assign wr_addr_o           = base_q + ADDR_W'(wr_cnt) * ADDR_W'(ROW_STRIDE);
    assign err_o               = err_q;

endmodule

// File: tb/tb_sarray_storec_drain.sv
// Scoreboard bench for sarray_storec_drain: a latency-3 array model feeds rows, a monitor checks every write.
// Expected tag-error behaviour follows the SARRAY_DRAIN_CNT_CHECK_EN build macro.
module tb_sarray_storec_drain;

    localparam int DATA_W = 512;
    localparam int CNT_W  = 8;
    localparam int ADDR_W = 32;
    localparam int LAT    = 3;

    logic              clk;
    logic              rst;
    logic              start_i;
    logic [CNT_W-1:0]  rows_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic              busy_o, done_o, post_storec_valid_o;
    logic              bot_valid_i;
    logic [CNT_W-1:0]  bot_cnt_i;
    logic [DATA_W-1:0] bot_data_i;
    logic              wr_valid_o, wr_ready_i;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [DATA_W-1:0] wr_data_o;
    logic              err_o;

    sarray_storec_drain dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_i             (start_i),
        .rows_i              (rows_i),
        .base_addr_i         (base_addr_i),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .post_storec_valid_o (post_storec_valid_o),
        .bot_valid_i         (bot_valid_i),
        .bot_cnt_i           (bot_cnt_i),
        .bot_data_i          (bot_data_i),
        .wr_valid_o          (wr_valid_o),
        .wr_ready_i          (wr_ready_i),
        .wr_addr_o           (wr_addr_o),
        .wr_data_o           (wr_data_o),
        .err_o               (err_o)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   dones  = 0;
    int   writes = 0;
    int   ready_mode = 0;
    int   cur_tile = 0;
    int   bad_idx = -1;
    int   inject_req = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DATA_W-1:0] rowData(input int tile, input int idx);
        logic [31:0] w;
        w = (tile << 16) | idx;
        return {16{w}};
    endfunction

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                               input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=timeout expected=event", name);
    endtask

    task automatic applyStimulus(input int rows, input logic [ADDR_W-1:0] base, input int tile);
        @(negedge clk);
        cur_tile    = tile;
        start_i     = 1'b1;
        rows_i      = CNT_W'(rows);
        base_addr_i = base;
        for (int i = 0; i < rows; i++) begin
            exp_t e;
            e.addr = base + ADDR_W'(i * 64);
            e.data = rowData(tile, i);
            sb.push_back(e);
        end
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string name);
        int n = 0;
        while (!done_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done_o) failNow(name);
    endtask

    // Array model: each sampled shift request returns one row LAT cycles later.
    initial begin
        logic pipe [LAT];
        logic req, out;
        int   arr_idx = 0;
        int   inject_ack = 0;
        bot_valid_i = 1'b0;
        bot_cnt_i   = '0;
        bot_data_i  = '0;
        for (int i = 0; i < LAT; i++) pipe[i] = 1'b0;
        forever begin
            @(negedge clk);
            req = post_storec_valid_o;
            if (!busy_o) arr_idx = 0;
            @(posedge clk);
            #1;
            if (rst) begin
                for (int i = 0; i < LAT; i++) pipe[i] = 1'b0;
                bot_valid_i = 1'b0;
            end else begin
                out = pipe[LAT-1];
                for (int i = LAT-1; i > 0; i--) pipe[i] = pipe[i-1];
                pipe[0] = req;
                if (out) begin
                    bot_valid_i = 1'b1;
                    bot_cnt_i   = (arr_idx == bad_idx) ? CNT_W'(5) : CNT_W'(arr_idx);
                    bot_data_i  = rowData(cur_tile, arr_idx);
                    arr_idx++;
                end else if (inject_ack != inject_req) begin
                    bot_valid_i = 1'b1;
                    bot_cnt_i   = '0;
                    bot_data_i  = {16{32'hDEADBEEF}};
                    inject_ack++;
                end else begin
                    bot_valid_i = 1'b0;
                end
            end
        end
    end

    initial begin
        wr_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       wr_ready_i = 1'b1;
                1:       wr_ready_i = 1'b0;
                default: wr_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every write handshake and checks hold-while-stalled.
    initial begin
        logic              stall_prev = 1'b0;
        logic [ADDR_W-1:0] held_addr = '0;
        logic [DATA_W-1:0] held_data = '0;
        forever begin
            @(negedge clk);
            if (post_storec_valid_o) pulses++;
            if (done_o) dones++;
            if (stall_prev) begin
                checkOutput("wr_valid_hold", DATA_W'(wr_valid_o), DATA_W'(1));
                checkOutput("wr_addr_hold", DATA_W'(wr_addr_o), DATA_W'(held_addr));
                checkOutput("wr_data_hold", wr_data_o, held_data);
            end
            if (wr_valid_o && wr_ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write actual=%0h expected=none", wr_addr_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("wr_addr", DATA_W'(wr_addr_o), DATA_W'(e.addr));
                    checkOutput("wr_data", wr_data_o, e.data);
                end
                writes++;
            end
            stall_prev = wr_valid_o && !wr_ready_i;
            held_addr  = wr_addr_o;
            held_data  = wr_data_o;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0, d0, w0, n;
        rst         = 1'b1;
        start_i     = 1'b0;
        rows_i      = '0;
        base_addr_i = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", DATA_W'(busy_o), '0);
        checkOutput("reset_done", DATA_W'(done_o), '0);
        checkOutput("reset_post", DATA_W'(post_storec_valid_o), '0);
        checkOutput("reset_wr_valid", DATA_W'(wr_valid_o), '0);
        checkOutput("reset_err", DATA_W'(err_o), '0);
        checkOutput("reset_wr_addr", DATA_W'(wr_addr_o), '0);
        rst = 1'b0;

        // Basic 4-row tile with store always ready.
        p0 = pulses; d0 = dones;
        applyStimulus(4, 32'h1000, 1);
        waitDone(100, "t1_done_timeout");
        @(negedge clk);
        checkOutput("t1_pulses", DATA_W'(pulses - p0), DATA_W'(4));
        checkOutput("t1_done_count", DATA_W'(dones - d0), DATA_W'(1));
        checkOutput("t1_done_pulse_width", DATA_W'(done_o), '0);
        checkOutput("t1_err", DATA_W'(err_o), '0);
        checkOutput("t1_sb_empty", DATA_W'(sb.size()), '0);

        // Back-pressure: requests must stop at FIFO_DEPTH credits.
        ready_mode = 1;
        p0 = pulses;
        applyStimulus(20, 32'h8000, 2);
        repeat (50) @(negedge clk);
        checkOutput("t2_pulses_capped", DATA_W'(pulses - p0), DATA_W'(8));
        checkOutput("t2_err_stalled", DATA_W'(err_o), '0);
        ready_mode = 0;
        waitDone(300, "t2_done_timeout");
        @(negedge clk);
        checkOutput("t2_pulses_total", DATA_W'(pulses - p0), DATA_W'(20));
        checkOutput("t2_err", DATA_W'(err_o), '0);
        checkOutput("t2_sb_empty", DATA_W'(sb.size()), '0);

        // Row 2 carries a wrong tag; data is still stored either way.
        bad_idx = 2;
        applyStimulus(6, 32'h4000, 3);
        waitDone(100, "t3_done_timeout");
        @(negedge clk);
        bad_idx = -1;
`ifdef SARRAY_DRAIN_CNT_CHECK_EN
        checkOutput("t3_err_tag", DATA_W'(err_o), DATA_W'(1));
`else
        checkOutput("t3_err_tag_ignored", DATA_W'(err_o), '0);
`endif
        checkOutput("t3_sb_empty", DATA_W'(sb.size()), '0);

        // Zero-row tile finishes next cycle with no request; start clears err.
        p0 = pulses;
        @(negedge clk);
        start_i = 1'b1;
        rows_i  = '0;
        @(negedge clk);
        start_i = 1'b0;
        checkOutput("t4_zero_done", DATA_W'(done_o), DATA_W'(1));
        checkOutput("t4_zero_err_cleared", DATA_W'(err_o), '0);
        @(negedge clk);
        checkOutput("t4_zero_pulses", DATA_W'(pulses - p0), '0);
        checkOutput("t4_zero_idle", DATA_W'(busy_o), '0);

        // Row arriving while idle is dropped and flagged.
        w0 = writes;
        inject_req++;
        repeat (3) @(negedge clk);
        checkOutput("t4_idle_row_err", DATA_W'(err_o), DATA_W'(1));
        checkOutput("t4_idle_row_no_write", DATA_W'(writes - w0), '0);

        // Reset mid-tile, then a clean tile afterwards.
        w0 = writes;
        applyStimulus(10, 32'h3000, 5);
        n = 0;
        while ((writes - w0) < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if ((writes - w0) < 3) failNow("t5_partial_timeout");
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        checkOutput("t5_rst_busy", DATA_W'(busy_o), '0);
        checkOutput("t5_rst_done", DATA_W'(done_o), '0);
        checkOutput("t5_rst_post", DATA_W'(post_storec_valid_o), '0);
        checkOutput("t5_rst_wr_valid", DATA_W'(wr_valid_o), '0);
        checkOutput("t5_rst_err", DATA_W'(err_o), '0);
        checkOutput("t5_rst_wr_addr", DATA_W'(wr_addr_o), '0);
        checkOutput("t5_rst_wr_data", wr_data_o, '0);
        rst = 1'b0;
        p0 = pulses;
        applyStimulus(4, 32'h1000, 6);
        waitDone(100, "t5_done_timeout");
        @(negedge clk);
        checkOutput("t5_pulses", DATA_W'(pulses - p0), DATA_W'(4));
        checkOutput("t5_err", DATA_W'(err_o), '0);
        checkOutput("t5_sb_empty", DATA_W'(sb.size()), '0);

        // Full 255-row tile against a random store ready.
        ready_mode = 2;
        w0 = writes;
        applyStimulus(255, 32'h0002_0000, 7);
        waitDone(4000, "t6_done_timeout");
        @(negedge clk);
        ready_mode = 0;
        checkOutput("t6_writes", DATA_W'(writes - w0), DATA_W'(255));
        checkOutput("t6_err", DATA_W'(err_o), '0);
        checkOutput("t6_sb_empty", DATA_W'(sb.size()), '0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
